mux_nto1_rr_cond: RTL and testbench

MUX_NTO1_RR_COND -- requirements
Module: mux_nto1_rr_cond

---
 rtl/mux_nto1_rr_cond.sv | 118 +++++++++++
 tb/tb_mux_nto1_rr_cond.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mux_nto1_rr_cond.sv
// mux_nto1_rr_cond: N-to-1 registered channel mux with two selection modes.
// In external mode the selector input picks the channel. In round-robin mode
// a small FSM waits in IDLE for channel 0 to be valid, then walks through all
// channels one per cycle. It drops back to IDLE when the walk reaches
// channel 0 again and no channel is valid.
// Every output comes straight from a register, so there is no combinational
// path from any input to any output.
//
// Handshake: valid_out qualifies data_out. valid_out is valid_in of the
// selected channel, delayed by one clock. There is no ready/backpressure: the
// consumer must accept every cycle in which valid_out=1. data_out holds its
// last valid value while valid_out=0.

module mux_nto1_rr_cond #(
  parameter int WIDTH  = 8,
  parameter int NUM_CH = 4,
  localparam int SELW  = $clog2(NUM_CH)
) (
  input  logic                    clk_4f,
  input  logic                    reset_L,
  input  logic                    mode_rr,
  input  logic [SELW-1:0]         selector,
  input  logic [NUM_CH-1:0]       valid_in,
  input  logic [NUM_CH*WIDTH-1:0] data_in,
  output logic                    valid_out,
  output logic [WIDTH-1:0]        data_out,
  output logic [SELW-1:0]         sel_out,
  output logic                    active
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [SELW-1:0]   rr_cnt;
  logic [SELW-1:0]   rr_cnt_next;
  logic [SELW-1:0]   sel;
  logic [WIDTH-1:0]  sel_data;
  logic              sel_valid;

  // FSM state and round-robin counter register
  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) begin
      state  <= IDLE;
      rr_cnt <= '0;
    end else begin
      state  <= state_next;
      rr_cnt <= rr_cnt_next;
    end
  end

  // Effective select, next FSM state and next counter value
  always_comb begin
    sel         = '0;
    state_next  = state;
    rr_cnt_next = rr_cnt;
    if (!mode_rr) begin
      // External mode always parks the round-robin logic at its start point
      sel         = selector;
      state_next  = IDLE;
      rr_cnt_next = '0;
    end else begin
      case (state)
        IDLE: begin
          // Channel 0 is consumed in the same cycle the walk starts
          sel = '0;
          if (valid_in[0]) begin
            state_next  = ACTIVE;
            rr_cnt_next = SELW'(1);
          end else begin
            state_next  = IDLE;
            rr_cnt_next = '0;
          end
        end
        ACTIVE: begin
          sel = rr_cnt;
          if ((rr_cnt == '0) && (valid_in == '0)) begin
            state_next  = IDLE;
            rr_cnt_next = '0;
          end else begin
            rr_cnt_next = rr_cnt + SELW'(1);
          end
        end
        default: begin
          state_next  = IDLE;
          rr_cnt_next = '0;
        end
      endcase
    end
  end

  // Extract the selected channel's valid bit and data word
  always_comb begin
    sel_valid = valid_in[sel];
    sel_data  = data_in[sel*WIDTH +: WIDTH];
  end

  // Output register stage; data holds while the selected channel is idle
  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) begin
      valid_out <= 1'b0;
      data_out  <= '0;
      sel_out   <= '0;
    end else begin
      valid_out <= sel_valid;
      sel_out   <= sel;
      if (sel_valid) begin
        data_out <= sel_data;
      end
    end
  end

  assign active = (state == ACTIVE);

endmodule

// File: tb/tb_mux_nto1_rr_cond.sv
// tb_mux_nto1_rr_cond: directed bench for mux_nto1_rr_cond (WIDTH=8, NUM_CH=4).
// A reference model predicts the outputs every cycle. Hand-computed literal
// checks pin the model's expected values at key points.

module tb_mux_nto1_rr_cond;

  localparam int WIDTH  = 8;
  localparam int NUM_CH = 4;
  localparam int SELW   = 2;

  logic                    clk_4f;
  logic                    reset_L;
  logic                    mode_rr;
  logic [SELW-1:0]         selector;
  logic [NUM_CH-1:0]       valid_in;
  logic [NUM_CH*WIDTH-1:0] data_in;
  logic                    valid_out;
  logic [WIDTH-1:0]        data_out;
  logic [SELW-1:0]         sel_out;
  logic                    active;

  int n_checks;
  int n_pass;
  logic cmp_en;

  mux_nto1_rr_cond #(.WIDTH(WIDTH), .NUM_CH(NUM_CH)) dut (
    .clk_4f    (clk_4f),
    .reset_L   (reset_L),
    .mode_rr   (mode_rr),
    .selector  (selector),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .valid_out (valid_out),
    .data_out  (data_out),
    .sel_out   (sel_out),
    .active    (active)
  );

  // ---------------- clock / reset ----------------
  initial clk_4f = 1'b0;
  always #5 clk_4f = ~clk_4f;

  // ---------------- reference model ----------------
  // The walk is modelled as an unbounded phase count. The channel in turn is
  // phase mod NUM_CH.
  bit        m_running;
  int        m_phase;
  bit        exp_valid;
  int        exp_sel;
  logic [7:0] exp_data;

  always @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) begin
      m_running = 0;
      m_phase   = 0;
      exp_valid = 0;
      exp_sel   = 0;
      exp_data  = 8'h00;
    end else begin
      int s;
      if (!mode_rr)        s = int'(selector);
      else if (!m_running) s = 0;
      else                 s = m_phase % NUM_CH;
      exp_valid = valid_in[s];
      exp_sel   = s;
      if (valid_in[s]) exp_data = data_in[s*WIDTH +: WIDTH];
      if (!mode_rr) begin
        m_running = 0;
        m_phase   = 0;
      end else if (!m_running) begin
        if (valid_in[0]) begin
          m_running = 1;
          m_phase   = 1;
        end else begin
          m_phase = 0;
        end
      end else if ((m_phase % NUM_CH == 0) && (valid_in == 0)) begin
        m_running = 0;
        m_phase   = 0;
      end else begin
        m_phase = m_phase + 1;
      end
    end
  end

  // ---------------- scoreboard / checks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Compare the DUT against the model shortly after every active edge
  always @(posedge clk_4f) begin
    #1;
    if (reset_L && cmp_en) begin
      check("model_valid_out", {31'd0, valid_out}, {31'd0, exp_valid});
      check("model_sel_out",   {30'd0, sel_out},   exp_sel);
      check("model_data_out",  {24'd0, data_out},  {24'd0, exp_data});
      check("model_active",    {31'd0, active},    {31'd0, m_running});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input logic m, input logic [SELW-1:0] s, input logic [NUM_CH-1:0] v);
    @(negedge clk_4f);
    mode_rr  = m;
    selector = s;
    valid_in = v;
    @(posedge clk_4f);
    #1;
  endtask

  task automatic check_out(input string name, input logic v, input logic [7:0] d,
                           input logic [1:0] s, input logic a);
    check({name, "_valid"},  {31'd0, valid_out}, {31'd0, v});
    check({name, "_data"},   {24'd0, data_out},  {24'd0, d});
    check({name, "_sel"},    {30'd0, sel_out},   {30'd0, s});
    check({name, "_active"}, {31'd0, active},    {31'd0, a});
  endtask

  logic [7:0] rr_seq [5];

  // ---------------- directed stimulus ----------------
  initial begin
    n_checks = 0;
    n_pass   = 0;
    cmp_en   = 1'b0;
    reset_L  = 1'b0;
    mode_rr  = 1'b0;
    selector = '0;
    valid_in = '0;
    data_in  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    rr_seq   = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA0};

    repeat (2) @(posedge clk_4f);
    #1;
    check_out("reset", 1'b0, 8'h00, 2'd0, 1'b0);
    @(negedge clk_4f);
    reset_L = 1'b1;
    cmp_en  = 1'b1;

    // Round-robin mode with no traffic: stays idle
    repeat (5) step(1'b1, 2'd0, 4'b0000);
    check_out("rr_idle", 1'b0, 8'h00, 2'd0, 1'b0);

    // Full round-robin walk over all channels
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 2'd0, 4'b1111);
      check({"rr_walk_data"}, {24'd0, data_out}, {24'd0, rr_seq[i]});
      check({"rr_walk_sel"},  {30'd0, sel_out},  i % NUM_CH);
      check({"rr_walk_valid"}, {31'd0, valid_out}, 32'd1);
      if (i > 0) check("rr_walk_active", {31'd0, active}, 32'd1);
    end

    // Walk on to the counter-at-zero point, then starve all channels
    repeat (3) step(1'b1, 2'd0, 4'b1111);
    check_out("rr_before_drop", 1'b1, 8'hA3, 2'd3, 1'b1);
    step(1'b1, 2'd0, 4'b0000);
    check_out("rr_drop", 1'b0, 8'hA3, 2'd0, 1'b0);

    // External selector mode
    data_in = {8'h11, 8'h5C, 8'h22, 8'h33};
    step(1'b0, 2'd2, 4'b0100);
    check_out("ext_sel2", 1'b1, 8'h5C, 2'd2, 1'b0);
    step(1'b0, 2'd2, 4'b0000);
    check_out("ext_sel2_hold", 1'b0, 8'h5C, 2'd2, 1'b0);
    for (int i = 0; i < NUM_CH; i++) step(1'b0, SELW'(i), 4'b1010);
    check_out("ext_walk", 1'b1, 8'h11, 2'd3, 1'b0);

    // Mode switch away from ACTIVE, then restart gated by channel 0
    data_in = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    step(1'b1, 2'd0, 4'b1111);
    step(1'b1, 2'd0, 4'b1111);
    check_out("sw_active", 1'b1, 8'hA1, 2'd1, 1'b1);
    step(1'b0, 2'd1, 4'b1111);
    check_out("sw_ext", 1'b1, 8'hA1, 2'd1, 1'b0);
    step(1'b1, 2'd3, 4'b1110);
    check_out("sw_wait0", 1'b0, 8'hA1, 2'd0, 1'b0);
    step(1'b1, 2'd3, 4'b1110);
    check_out("sw_wait1", 1'b0, 8'hA1, 2'd0, 1'b0);
    step(1'b1, 2'd0, 4'b1111);
    check_out("sw_restart", 1'b1, 8'hA0, 2'd0, 1'b1);
    step(1'b1, 2'd0, 4'b1111);
    check_out("sw_next", 1'b1, 8'hA1, 2'd1, 1'b1);

    // Asynchronous reset mid-stream, between edges
    #3;
    reset_L = 1'b0;
    #1;
    check_out("async_rst", 1'b0, 8'h00, 2'd0, 1'b0);
    @(posedge clk_4f);
    #1;
    check_out("rst_held", 1'b0, 8'h00, 2'd0, 1'b0);
    @(negedge clk_4f);
    mode_rr  = 1'b1;
    valid_in = 4'b1111;
    #2;
    reset_L = 1'b1;
    #1;
    check_out("rst_release", 1'b0, 8'h00, 2'd0, 1'b0);
    @(posedge clk_4f);
    #1;
    check_out("rst_restart", 1'b1, 8'hA0, 2'd0, 1'b1);
    step(1'b1, 2'd0, 4'b1111);
    check_out("rst_next", 1'b1, 8'hA1, 2'd1, 1'b1);

    repeat (2) step(1'b1, 2'd0, 4'b0000);
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
